// File: rtl/ram_sdp_be_lat.sv
// Simple dual-port RAM with byte-enable writes, RD_LATENCY (1 or 2) registered read, WR_MODE collision policy; optional per-byte parity under RAM_SDP_PARITY_EN.
// Latency: rd_data/rd_valid update RD_LATENCY cycles after the edge that samples rd_en; one read accepted every cycle, results in order.
// Backpressure: none; both ports accept every cycle and read results cannot be stalled.
module ram_sdp_be_lat #(
   parameter int AWIDTH     = 3,
   parameter int DWIDTH     = 32,
   parameter int RD_LATENCY = 1,
   parameter int WR_MODE    = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [AWIDTH-1:0]      wr_addr,
   input  logic [DWIDTH/8-1:0]    wr_be,
   input  logic [DWIDTH-1:0]      wr_data,
   input  logic                   rd_en,
   input  logic [AWIDTH-1:0]      rd_addr,
   output logic [DWIDTH-1:0]      rd_data,
   output logic                   rd_valid,
   output logic                   rd_perr
);

   localparam int DEPTH  = 1 << AWIDTH;
   localparam int NBYTES = DWIDTH / 8;

   // Bad configurations stop elaboration rather than building a broken store.
   if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
      $fatal(1, "ram_sdp_be_lat: RD_LATENCY must be 1 or 2");
   end
   if ((DWIDTH % 8) != 0) begin : g_bad_width
      $fatal(1, "ram_sdp_be_lat: DWIDTH must be a multiple of 8");
   end

   logic [DWIDTH-1:0] mem [DEPTH];

   logic              s0_valid;
   logic [AWIDTH-1:0] s0_addr;
   logic [DWIDTH-1:0] s0_old;
   logic [DWIDTH-1:0] s0_word;

   // Byte-masked write; the array itself is never reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // Stage 0: capture the read address and the pre-write word at the sample edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s0_valid <= 1'b0;
         s0_addr  <= '0;
         s0_old   <= '0;
      end else begin
         s0_valid <= rd_en;
         if (rd_en) begin
            s0_addr <= rd_addr;
            s0_old  <= mem[rd_addr];
         end
      end
   end

   // Read-first uses the word captured before the same-edge write; write-through
   // reads the array after that write has landed.
   assign s0_word = (WR_MODE == 1) ? mem[s0_addr] : s0_old;

`ifdef RAM_SDP_PARITY_EN
   logic [NBYTES-1:0] par_mem [DEPTH];
   logic [NBYTES-1:0] s0_par_old;
   logic [NBYTES-1:0] s0_par;
   logic              s0_perr;

   function automatic logic [NBYTES-1:0] byte_par(input logic [DWIDTH-1:0] d);
      logic [NBYTES-1:0] p;
      p = '0;
      for (int i = 0; i < NBYTES; i++) p[i] = ^d[8*i +: 8];
      return p;
   endfunction

   // Even parity per byte, written under the same byte enables as the data.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) par_mem[wr_addr][i] <= ^wr_data[8*i +: 8];
         end
      end
   end

   // Stored parity follows the same read-first capture as the data word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)      s0_par_old <= '0;
      else if (rd_en) s0_par_old <= par_mem[rd_addr];
   end

   assign s0_par  = (WR_MODE == 1) ? par_mem[s0_addr] : s0_par_old;
   assign s0_perr = |(s0_par ^ byte_par(s0_word));
`else
   assign rd_perr = 1'b0;
`endif

   if (RD_LATENCY == 2) begin : g_lat2
      logic              s1_valid;
      logic [DWIDTH-1:0] s1_data;
`ifdef RAM_SDP_PARITY_EN
      logic              s1_perr;
`endif

      // Extra pipeline stage, then the output register which holds between reads.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
`ifdef RAM_SDP_PARITY_EN
            s1_perr  <= 1'b0;
            rd_perr  <= 1'b0;
`endif
         end else begin
            s1_valid <= s0_valid;
            rd_valid <= s1_valid;
            if (s0_valid) s1_data <= s0_word;
            if (s1_valid) rd_data <= s1_data;
`ifdef RAM_SDP_PARITY_EN
            if (s0_valid) s1_perr <= s0_perr;
            if (s1_valid) rd_perr <= s1_perr;
`endif
         end
      end
   end else begin : g_lat1
      // Output register loads the selected word; holds its value between reads.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
`ifdef RAM_SDP_PARITY_EN
            rd_perr  <= 1'b0;
`endif
         end else begin
            rd_valid <= s0_valid;
            if (s0_valid) rd_data <= s0_word;
`ifdef RAM_SDP_PARITY_EN
            if (s0_valid) rd_perr <= s0_perr;
`endif
         end
      end
   end

endmodule
